uart_rx_periph: RTL and testbench

Memory-mapped UART receiver peripheral that responds to the CPU's single-cycle data bus (`rd`/`wr`/`addr`/`wdata`/`rdata`) in the 0x4000_0000 peripheral window. It does the following:
- Samples the serial `UART_RX` line at 16x oversampling and frames 8N1 bytes.
- Buffers received bytes in a small FIFO.
- Exposes the FIFO and status/control through two bus registers.
- Raises a level interrupt toward the CPU's IRQ input.

---
 rtl/uart_rx_periph_if.sv | 11 +
 rtl/uart_rx_periph.sv | 183 ++++++++++++++++++
 tb/tb_uart_rx_periph.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_periph_if.sv
// Single-cycle CPU data bus as seen by the UART receiver peripheral.
interface uart_rx_periph_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rd, output wr, output addr, output wdata, input rdata);
  modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/uart_rx_periph.sv
// Memory-mapped 8N1 UART receiver: 16x oversampled framing, byte FIFO,
// RXD/CON registers and a level interrupt.
//
// state | meaning
// IDLE  | line idle, waiting for rx_s low
// START | counting to mid start bit, rejects false starts
// DATA  | sampling 8 data bits LSB first, one per OVERSAMPLE ticks
// STOP  | sampling stop bit, push byte or flag framing error
module uart_rx_periph #(
  parameter int FIFO_DEPTH = 4,
  parameter int OVERSAMPLE = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             baud_tick,
  input  logic             UART_RX,
  uart_rx_periph_if.slave  bus,
  output logic             irqout
);

  localparam logic [31:0] RXD_ADDR = 32'h4000_001C;
  localparam logic [31:0] CON_ADDR = 32'h4000_0020;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);
  localparam logic [PW:0]   DEPTH_C = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] tick_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_q;
  logic          rx_meta;
  logic          rx_s;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          ie;
  logic          ovr;
  logic          ferr;

  logic tick_done;
  logic stop_sample;
  logic push_req;
  logic ferr_set;
  logic ovr_set;
  logic rxd_sel;
  logic con_sel;
  logic con_wr;
  logic fifo_empty;
  logic fifo_full;
  logic pop;
  logic push;
  logic unused_wdata;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= UART_RX;
      rx_s    <= rx_meta;
    end
  end

  assign tick_done   = baud_tick && (tick_cnt == '0);
  assign stop_sample = (state == STOP) && tick_done;
  assign push_req    = stop_sample && rx_s;
  assign ferr_set    = stop_sample && !rx_s;

  // Tick counter runs down to zero; the sample is taken on the tick that finds it at zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shift_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            tick_cnt <= HALF_M1;
          end
        end
        START: begin
          if (baud_tick) begin
            if (tick_cnt == '0) begin
              if (rx_s) begin
                state <= IDLE;
              end else begin
                state    <= DATA;
                tick_cnt <= FULL_M1;
                bit_idx  <= '0;
              end
            end else begin
              tick_cnt <= tick_cnt - 1'b1;
            end
          end
        end
        DATA: begin
          if (baud_tick) begin
            if (tick_cnt == '0) begin
              shift_q  <= {rx_s, shift_q[7:1]};
              tick_cnt <= FULL_M1;
              if (bit_idx == 3'd7) state <= STOP;
              else                 bit_idx <= bit_idx + 3'd1;
            end else begin
              tick_cnt <= tick_cnt - 1'b1;
            end
          end
        end
        STOP: begin
          if (baud_tick) begin
            if (tick_cnt == '0) state <= IDLE;
            else                tick_cnt <= tick_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rxd_sel    = (bus.addr == RXD_ADDR);
  assign con_sel    = (bus.addr == CON_ADDR);
  assign con_wr     = bus.wr && con_sel;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);
  assign pop        = bus.rd && rxd_sel && !fifo_empty;
  // A pop in the same cycle frees the head slot, so a full FIFO still accepts the push.
  assign push       = push_req && (!fifo_full || pop);
  assign ovr_set    = push_req && fifo_full && !pop;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shift_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ie   <= 1'b0;
      ovr  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      if (con_wr) ie <= bus.wdata[0];
      if (ovr_set)                      ovr <= 1'b1;
      else if (con_wr && bus.wdata[2])  ovr <= 1'b0;
      if (ferr_set)                     ferr <= 1'b1;
      else if (con_wr && bus.wdata[3])  ferr <= 1'b0;
    end
  end

  always_comb begin
    bus.rdata = 32'h0;
    if (bus.rd) begin
      if (rxd_sel && !fifo_empty) bus.rdata = {24'h0, mem[rd_ptr]};
      else if (con_sel)           bus.rdata = {28'h0, ferr, ovr, !fifo_empty, ie};
    end
  end

  assign irqout       = ie && !fifo_empty;
  assign unused_wdata = ^{bus.wdata[31:4], bus.wdata[1]};

endmodule

// File: tb/tb_uart_rx_periph.sv
// Bench for uart_rx_periph: directed vector table, corner-case sequences and
// randomized frames checked against a queue-based model.
module tb_uart_rx_periph;

  localparam logic [31:0] RXD = 32'h4000_001C;
  localparam logic [31:0] CON = 32'h4000_0020;
  localparam int BIT_CLK = 64;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic baud_tick = 1'b0;
  logic UART_RX = 1'b1;
  logic irqout;

  uart_rx_periph_if bif ();

  uart_rx_periph #(.FIFO_DEPTH(4), .OVERSAMPLE(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .baud_tick (baud_tick),
    .UART_RX   (UART_RX),
    .bus       (bif.slave),
    .irqout    (irqout)
  );

  always #5 clk = ~clk;

  // baud_tick every 4 clk, changed on the falling edge
  initial begin
    int div;
    div = 0;
    forever begin
      @(negedge clk);
      div = (div + 1) % 4;
      baud_tick = (div == 0);
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // All bus/line tasks start and end on a falling edge.
  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic irq);
    bif.rd = 1'b1;
    bif.addr = a;
    #1;
    d = bif.rdata;
    irq = irqout;
    @(negedge clk);
    bif.rd = 1'b0;
    bif.addr = 32'h0;
  endtask

  task automatic rd_chk(input string name, input logic [31:0] a, input logic [31:0] exp,
                        input logic exp_irq);
    logic [31:0] d;
    logic irq;
    bus_read(a, d, irq);
    check(name, d, exp);
    check({name, "_irq"}, {31'h0, irq}, {31'h0, exp_irq});
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bif.wr = 1'b1;
    bif.addr = a;
    bif.wdata = d;
    @(negedge clk);
    bif.wr = 1'b0;
    bif.addr = 32'h0;
    bif.wdata = 32'h0;
  endtask

  // Stop level is held long enough for the stop sample, then the line returns high.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    UART_RX = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      UART_RX = b[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    UART_RX = stop_bit;
    repeat (40) @(negedge clk);
    UART_RX = 1'b1;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  // Start detection lands 3 posedges after the fall (2-flop sync + IDLE decode);
  // the push then happens on the 152nd baud tick (8 to mid start, 9 x 16 after).
  task automatic send_frame_pop(input logic [7:0] b, output logic [31:0] d);
    logic [31:0] dd;
    dd = 32'hDEAD_BEEF;
    fork
      send_frame(b, 1'b1);
      begin
        int n;
        n = 0;
        repeat (3) @(posedge clk);
        while (n < 152) begin
          @(negedge clk);
          #1;
          if (baud_tick) n++;
        end
        bif.rd = 1'b1;
        bif.addr = RXD;
        #1;
        dd = bif.rdata;
        @(negedge clk);
        bif.rd = 1'b0;
        bif.addr = 32'h0;
      end
    join
    d = dd;
  endtask

  typedef enum logic [1:0] {OP_WR, OP_RD, OP_TX, OP_TXBAD} op_e;
  typedef struct {
    op_e         op;
    logic [31:0] addr;
    logic [31:0] val;
    logic [31:0] exp;
    logic        exp_irq;
  } vec_t;

  function automatic vec_t mk(input op_e op, input logic [31:0] a, input logic [31:0] val,
                              input logic [31:0] exp, input logic irq);
    vec_t v;
    v.op = op;
    v.addr = a;
    v.val = val;
    v.exp = exp;
    v.exp_irq = irq;
    return v;
  endfunction

  vec_t vecs[$];
  logic [7:0] q[$];
  logic m_ie, m_ovr, m_ferr;

  initial begin
    logic [31:0] d;
    logic irq;

    bif.rd = 1'b0;
    bif.wr = 1'b0;
    bif.addr = 32'h0;
    bif.wdata = 32'h0;

    vecs.push_back(mk(OP_WR, CON, 32'h1, 0, 0));
    vecs.push_back(mk(OP_TX, 0, 32'hA5, 0, 0));
    vecs.push_back(mk(OP_RD, CON, 0, 32'h3, 1));
    vecs.push_back(mk(OP_RD, RXD, 0, 32'hA5, 1));
    vecs.push_back(mk(OP_RD, CON, 0, 32'h1, 0));
    vecs.push_back(mk(OP_TXBAD, 0, 32'h3C, 0, 0));
    vecs.push_back(mk(OP_RD, CON, 0, 32'h9, 0));
    vecs.push_back(mk(OP_RD, RXD, 0, 32'h0, 0));
    vecs.push_back(mk(OP_WR, CON, 32'h9, 0, 0));
    vecs.push_back(mk(OP_RD, CON, 0, 32'h1, 0));
    for (int i = 1; i <= 5; i++) vecs.push_back(mk(OP_TX, 0, 32'(i), 0, 0));
    vecs.push_back(mk(OP_RD, CON, 0, 32'h7, 1));
    vecs.push_back(mk(OP_WR, CON, 32'h5, 0, 0));
    vecs.push_back(mk(OP_RD, CON, 0, 32'h3, 1));
    for (int i = 1; i <= 4; i++) vecs.push_back(mk(OP_RD, RXD, 0, 32'(i), 1));
    vecs.push_back(mk(OP_RD, RXD, 0, 32'h0, 0));
    vecs.push_back(mk(OP_RD, CON, 0, 32'h1, 0));
    vecs.push_back(mk(OP_RD, 32'h4000_0024, 0, 32'h0, 0));
    vecs.push_back(mk(OP_RD, 32'h0000_0020, 0, 32'h0, 0));
    vecs.push_back(mk(OP_WR, 32'h4000_0021, 32'h0, 0, 0));
    vecs.push_back(mk(OP_RD, CON, 0, 32'h1, 0));
    vecs.push_back(mk(OP_WR, CON, 32'h0, 0, 0));
    vecs.push_back(mk(OP_RD, CON, 0, 32'h0, 0));

    // reset state
    repeat (3) @(negedge clk);
    #1;
    check("reset_rdata_idle", bif.rdata, 32'h0);
    check("reset_irq", {31'h0, irqout}, 32'h0);
    @(negedge clk);
    rd_chk("reset_con", CON, 32'h0, 1'b0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    rd_chk("post_reset_con", CON, 32'h0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      case (vecs[i].op)
        OP_WR:    bus_write(vecs[i].addr, vecs[i].val);
        OP_TX:    send_frame(vecs[i].val[7:0], 1'b1);
        OP_TXBAD: send_frame(vecs[i].val[7:0], 1'b0);
        default:  rd_chk($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp, vecs[i].exp_irq);
      endcase
    end

    // glitch: low for 3 baud ticks only
    UART_RX = 1'b0;
    repeat (12) @(negedge clk);
    UART_RX = 1'b1;
    repeat (100) @(negedge clk);
    rd_chk("glitch_con", CON, 32'h0, 1'b0);
    rd_chk("glitch_rxd", RXD, 32'h0, 1'b0);

    // pop aligned with a push into a full FIFO
    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1);
    rd_chk("full_con", CON, 32'h2, 1'b0);
    send_frame_pop(8'h15, d);
    check("samecyc_pop_data", d, 32'h11);
    rd_chk("samecyc_con", CON, 32'h2, 1'b0);
    for (int i = 0; i < 4; i++) rd_chk("samecyc_drain", RXD, 32'h12 + 32'(i), 1'b0);
    rd_chk("samecyc_empty", RXD, 32'h0, 1'b0);

    // pop aligned with the first push into an empty FIFO
    send_frame_pop(8'h66, d);
    check("firstpush_pop_data", d, 32'h0);
    rd_chk("firstpush_con", CON, 32'h2, 1'b0);
    rd_chk("firstpush_rxd", RXD, 32'h66, 1'b0);

    // reset during data bit 4
    bus_write(CON, 32'h1);
    send_frame(8'h42, 1'b1);
    rd_chk("prereset_con", CON, 32'h3, 1'b1);
    UART_RX = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      UART_RX = i[0];
      repeat (BIT_CLK) @(negedge clk);
    end
    UART_RX = 1'b1;
    repeat (32) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    rd_chk("midreset_con", CON, 32'h0, 1'b0);
    rd_chk("midreset_rxd", RXD, 32'h0, 1'b0);
    send_frame(8'h7E, 1'b1);
    rd_chk("after_reset_rxd", RXD, 32'h7E, 1'b0);

    // randomized frames, writes and reads against a queue model
    bus_write(CON, 32'hC);
    m_ie = 1'b0;
    m_ovr = 1'b0;
    m_ferr = 1'b0;
    q.delete();
    for (int it = 0; it < 24; it++) begin
      int r;
      int nrd;
      logic [7:0] b;
      logic good;
      logic [31:0] w;
      logic [31:0] exp;
      logic exp_irq;
      r = $urandom_range(0, 9);
      if (r < 7) begin
        b = 8'($urandom);
        good = ($urandom_range(0, 7) != 0);
        send_frame(b, good);
        if (!good)              m_ferr = 1'b1;
        else if (q.size() < 4)  q.push_back(b);
        else                    m_ovr = 1'b1;
      end else begin
        w = $urandom;
        bus_write(CON, w);
        m_ie = w[0];
        if (w[2]) m_ovr = 1'b0;
        if (w[3]) m_ferr = 1'b0;
      end
      nrd = $urandom_range(0, 2);
      for (int k = 0; k < nrd; k++) begin
        exp_irq = m_ie && (q.size() != 0);
        exp = (q.size() != 0) ? {24'h0, q.pop_front()} : 32'h0;
        rd_chk("rnd_rxd", RXD, exp, exp_irq);
      end
      exp_irq = m_ie && (q.size() != 0);
      rd_chk("rnd_con", CON, {28'h0, m_ferr, m_ovr, (q.size() != 0), m_ie}, exp_irq);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
